// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code tracker: pops bytes from a keyboard FIFO, decodes E0/F0 prefixes into make/break
// events, queues them behind valid/ready and tracks the held key. PS2_SHIFT_CASE_EN adds shift-aware ASCII.
module ps2_key_tracker #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned QDEPTH        = 4,
    parameter int unsigned FILTER_REPEAT = 1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             in_nextdata_n,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_break,
    output logic [7:0]       ev_ascii,
    output logic             held,
    output logic [8:0]       held_code,
    output logic [CNT_W-1:0] press_cnt,
    output logic             drop
);
    localparam int unsigned AW = $clog2(QDEPTH);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;
`ifdef PS2_SHIFT_CASE_EN
    typedef struct packed { logic [7:0] code; logic ext; logic brk; logic shift; } ev_t;
`else
    typedef struct packed { logic [7:0] code; logic ext; logic brk; } ev_t;
`endif

    logic             r_nextdata_n;
    logic [7:0]       r_byte;
    state_t           r_state, w_state_nxt;
    logic             w_gen, w_gen_ext, w_gen_brk, w_repeat, w_accept;
    logic [8:0]       w_key;
    logic             r_ev_vld;
    ev_t              r_ev, w_ev, w_head;
    ev_t              r_q [QDEPTH];
    logic [AW:0]      r_wp, r_rp;
    logic             w_empty, w_full, w_push, w_pop;
    logic             r_held;
    logic [8:0]       r_held_code;
    logic [CNT_W-1:0] r_press_cnt;
    logic             r_drop;

    function automatic logic [7:0] f_ascii(input logic [7:0] code, input logic upper);
        logic [7:0] a;
        case (code)
            8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
            8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
            8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
            8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
            8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
            8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            8'h52: a = 8'h27; 8'h41: a = 8'h2C; 8'h4E: a = 8'h2D; 8'h49: a = 8'h2E;
            8'h4A: a = 8'h2F; 8'h4C: a = 8'h3B; 8'h55: a = 8'h3D; 8'h54: a = 8'h5B;
            8'h5D: a = 8'h5C; 8'h5B: a = 8'h5D; 8'h0E: a = 8'h60;
            default: a = 8'h00;
        endcase
        if (upper && (a >= 8'h61) && (a <= 8'h7A)) a = a - 8'h20;
        return a;
    endfunction

    // Byte fetch: one pop strobe, then a forced bubble cycle
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_nextdata_n <= 1'b1;
            r_byte       <= 8'h00;
        end else begin
            r_nextdata_n <= !(in_ready && r_nextdata_n);
            if (in_ready && r_nextdata_n) r_byte <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Prefix parser; a latched byte is valid while the pop strobe is low
    always_comb begin
        w_state_nxt = r_state;
        w_gen       = 1'b0;
        w_gen_ext   = 1'b0;
        w_gen_brk   = 1'b0;
        if (!r_nextdata_n) begin
            case (r_state)
                S_IDLE: begin
                    if (r_byte == 8'hF0)      w_state_nxt = S_BRK;
                    else if (r_byte == 8'hE0) w_state_nxt = S_EXT;
                    else if (!(r_byte == 8'hAA || r_byte == 8'hFA ||
                               r_byte == 8'hFE || r_byte == 8'hEE)) w_gen = 1'b1;
                end
                S_EXT: begin
                    if (r_byte == 8'hF0) w_state_nxt = S_EXT_BRK;
                    else if (r_byte != 8'hE0) begin
                        w_gen       = 1'b1;
                        w_gen_ext   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BRK: begin
                    w_gen       = 1'b1;
                    w_gen_brk   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_EXT_BRK: begin
                    w_gen       = 1'b1;
                    w_gen_ext   = 1'b1;
                    w_gen_brk   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_key    = {w_gen_ext, r_byte};
    assign w_repeat = (FILTER_REPEAT != 0) && r_held && (r_held_code == w_key);
    assign w_accept = w_gen && (w_gen_brk || !w_repeat);

`ifdef PS2_SHIFT_CASE_EN
    logic r_shift, w_shift_nxt, w_shift_key;
    assign w_shift_key = !w_gen_ext && (r_byte == 8'h12 || r_byte == 8'h59);
    assign w_shift_nxt = (w_gen && w_shift_key) ? !w_gen_brk : r_shift;
    always_ff @(posedge clk) begin
        if (!clrn) r_shift <= 1'b0;
        else       r_shift <= w_shift_nxt;
    end
    assign w_ev = '{code: r_byte, ext: w_gen_ext, brk: w_gen_brk, shift: w_shift_nxt};
`else
    assign w_ev = '{code: r_byte, ext: w_gen_ext, brk: w_gen_brk};
`endif

    // Event stage and held-key / press tracking
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_ev_vld    <= 1'b0;
            r_ev        <= '0;
            r_held      <= 1'b0;
            r_held_code <= 9'h000;
            r_press_cnt <= '0;
        end else begin
            r_ev_vld <= w_accept;
            r_ev     <= w_ev;
            if (w_gen && !w_gen_brk && !w_repeat) begin
                r_press_cnt <= r_press_cnt + CNT_W'(1);
                r_held      <= 1'b1;
                r_held_code <= w_key;
            end else if (w_gen && w_gen_brk && (r_held_code == w_key)) begin
                r_held <= 1'b0;
            end
        end
    end

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_pop   = !w_empty && ev_ready;
    assign w_push  = r_ev_vld && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_drop <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + (AW+1)'(1);
            if (w_pop)  r_rp <= r_rp + (AW+1)'(1);
            if (r_ev_vld && !w_push) r_drop <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_q[r_wp[AW-1:0]] <= r_ev;
    end

    assign w_head        = r_q[r_rp[AW-1:0]];
    assign ev_valid      = !w_empty;
    assign ev_code       = w_empty ? 8'h00 : w_head.code;
    assign ev_ext        = !w_empty && w_head.ext;
    assign ev_break      = !w_empty && w_head.brk;
`ifdef PS2_SHIFT_CASE_EN
    assign ev_ascii      = (w_empty || w_head.ext) ? 8'h00 : f_ascii(w_head.code, w_head.shift);
`else
    assign ev_ascii      = (w_empty || w_head.ext) ? 8'h00 : f_ascii(w_head.code, 1'b0);
`endif
    assign in_nextdata_n = r_nextdata_n;
    assign held          = r_held;
    assign held_code     = r_held_code;
    assign press_cnt     = r_press_cnt;
    assign drop          = r_drop;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: a byte-stream reference model predicts events and
// tracker state; a negedge monitor pops expectations whenever the DUT hands over an event.
module tb_ps2_key_tracker;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned QDEPTH = 4;
    localparam int unsigned FILTER = 1;
    localparam int          LIMIT  = 600;

    logic             clk = 1'b0;
    logic             clrn = 1'b0;
    logic             in_ready = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_nextdata_n;
    logic             ev_valid;
    logic             ev_ready = 1'b0;
    logic [7:0]       ev_code;
    logic             ev_ext;
    logic             ev_break;
    logic [7:0]       ev_ascii;
    logic             held;
    logic [8:0]       held_code;
    logic [CNT_W-1:0] press_cnt;
    logic             drop;

    ps2_key_tracker #(.CNT_W(CNT_W), .QDEPTH(QDEPTH), .FILTER_REPEAT(FILTER)) dut (
        .clk(clk), .clrn(clrn), .in_ready(in_ready), .in_data(in_data),
        .in_nextdata_n(in_nextdata_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break), .ev_ascii(ev_ascii),
        .held(held), .held_code(held_code), .press_cnt(press_cnt), .drop(drop)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_ev = 0;
    int rdy_mode = 1;
    bit prev_low = 1'b0;

    logic [7:0]  src_q [$];
    logic [17:0] exp_q [$];

    // Reference model state
    bit               m_ext, m_brk, m_held, m_drop, m_shift, m_nopop;
    logic [8:0]       m_hcode;
    logic [CNT_W-1:0] m_cnt;

    logic [7:0] lt_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                  8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dg_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pc_codes [11] = '{8'h52, 8'h41, 8'h4E, 8'h49, 8'h4A, 8'h4C, 8'h55, 8'h54, 8'h5D, 8'h5B, 8'h0E};
    logic [7:0] pc_chars [11] = '{8'h27, 8'h2C, 8'h2D, 8'h2E, 8'h2F, 8'h3B, 8'h3D, 8'h5B, 8'h5C, 8'h5D, 8'h60};
    logic [7:0] pool [18]     = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h45, 8'h29, 8'h5A, 8'h12, 8'h59,
                                  8'h75, 8'h6B, 8'h52, 8'h0E, 8'h4A, 8'h66, 8'hAA, 8'h1A, 8'h35};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_ascii(input logic [7:0] c, input bit ext, input bit sh);
        if (ext) return 8'h00;
        for (int i = 0; i < 26; i++) if (lt_codes[i] == c) return (sh ? 8'h41 : 8'h61) + 8'(i);
        for (int i = 0; i < 10; i++) if (dg_codes[i] == c) return 8'h30 + 8'(i);
        for (int i = 0; i < 11; i++) if (pc_codes[i] == c) return pc_chars[i];
        return 8'h00;
    endfunction

    task automatic model_event(input bit ext, input bit brk, input logic [7:0] code);
        bit push;
        if (!brk) begin
            push = !(FILTER != 0 && m_held && m_hcode == {ext, code});
            if (push) begin
                m_cnt   = m_cnt + 1'b1;
                m_held  = 1'b1;
                m_hcode = {ext, code};
            end
        end else begin
            push = 1'b1;
            if (m_hcode == {ext, code}) m_held = 1'b0;
        end
`ifdef PS2_SHIFT_CASE_EN
        if (!ext && (code == 8'h12 || code == 8'h59)) m_shift = !brk;
`endif
        if (push) begin
            if (m_nopop && exp_q.size() >= QDEPTH) m_drop = 1'b1;
            else exp_q.push_back({code, ext, brk, m_ascii(code, ext, m_shift)});
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_brk) begin
            model_event(m_ext, 1'b1, b);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (m_ext || !(b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE)) begin
            model_event(m_ext, 1'b0, b);
            m_ext = 1'b0;
        end
    endtask

    task automatic feed(input logic [7:0] b);
        model_byte(b);
        src_q.push_back(b);
    endtask

    task automatic paced_feed(input logic [7:0] b);
        int budget = 0;
        while (!(src_q.size() == 0 && exp_q.size() < QDEPTH) && budget < LIMIT) begin
            @(posedge clk); #1; budget++;
        end
        check("pace_timeout", 32'(budget >= LIMIT), 0);
        feed(b);
    endtask

    task automatic wait_drain(input string nm);
        int budget = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && budget < LIMIT) begin
            @(posedge clk); #1; budget++;
        end
        check({nm, "_drain_timeout"}, 32'(budget >= LIMIT), 0);
        repeat (6) begin @(posedge clk); #1; end
    endtask

    task automatic wait_src(input string nm);
        int budget = 0;
        while (src_q.size() != 0 && budget < LIMIT) begin
            @(posedge clk); #1; budget++;
        end
        check({nm, "_src_timeout"}, 32'(budget >= LIMIT), 0);
        repeat (8) begin @(posedge clk); #1; end
    endtask

    task automatic check_state(input string nm);
        check({nm, "_held"}, 32'({held, held_code}), 32'({m_held, m_hcode}));
        check({nm, "_press_cnt"}, 32'(press_cnt), 32'(m_cnt));
        check({nm, "_drop"}, 32'(drop), 32'(m_drop));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        clrn = 1'b0;
        src_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        check("rst_nextdata_n", 32'(in_nextdata_n), 1);
        check("rst_ev", 32'({ev_valid, ev_code, ev_ext, ev_break, ev_ascii}), 0);
        check("rst_held", 32'({held, held_code}), 0);
        check("rst_cnt_drop", 32'({press_cnt, drop}), 0);
        m_ext = 0; m_brk = 0; m_held = 0; m_drop = 0; m_shift = 0; m_nopop = 0;
        m_hcode = '0; m_cnt = '0;
        clrn = 1'b1;
    endtask

    // Source FIFO: pop on the strobe, present the new head before the next edge
    always @(negedge clk) begin
        if (clrn && !in_nextdata_n && src_q.size() > 0) void'(src_q.pop_front());
        in_ready = (src_q.size() > 0);
        in_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       ev_ready = 1'b0;
            1:       ev_ready = 1'b1;
            default: ev_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: compares each handed-over event with the oldest expectation
    always @(negedge clk) begin
        if (clrn) begin
            if (!in_nextdata_n) check("pop_pulse_width", 32'(prev_low), 0);
            prev_low = !in_nextdata_n;
            if (ev_valid && ev_ready) begin
                n_ev++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_event: got %0h expected none at %0t",
                             {ev_code, ev_ext, ev_break, ev_ascii}, $time);
                end else begin
                    check("event", 32'({ev_code, ev_ext, ev_break, ev_ascii}), 32'(exp_q.pop_front()));
                end
            end else if (!ev_valid) begin
                check("empty_outputs_zero", 32'({ev_code, ev_ext, ev_break, ev_ascii}), 0);
            end
        end else begin
            prev_low = 1'b0;
        end
    end

    initial begin
        int ev_mark;
        logic [7:0] k;
        rdy_mode = 1;
        repeat (3) @(posedge clk);
        do_reset();

        // Plain make then break
        feed(8'h1C);
        wait_drain("t1_make");
        check("t1_held_after_make", 32'({held, held_code}), 32'h21C);
        check("t1_press_cnt", 32'(press_cnt), 1);
        feed(8'hF0); feed(8'h1C);
        wait_drain("t1_break");
        check("t1_held_after_break", 32'(held), 0);
        check_state("t1");

        // Extended make/break
        feed(8'hE0); feed(8'h75);
        wait_drain("t2_make");
        check("t2_held_code", 32'({held, held_code}), 32'h375);
        feed(8'hE0); feed(8'hF0); feed(8'h75);
        wait_drain("t2_break");
        check_state("t2");

        // Typematic repeats
        do_reset();
        ev_mark = n_ev;
        feed(8'h1C); feed(8'h1C); feed(8'h1C); feed(8'hF0); feed(8'h1C);
        wait_drain("t3");
        check("t3_event_count", 32'(n_ev - ev_mark), (FILTER != 0) ? 2 : 4);
        check("t3_press_cnt", 32'(press_cnt), (FILTER != 0) ? 1 : 3);
        check_state("t3");

        // Queue overflow with a stalled consumer
        do_reset();
        rdy_mode = 0;
        m_nopop  = 1'b1;
        feed(8'h16); feed(8'h1E); feed(8'h26); feed(8'h25); feed(8'h2E);
        wait_src("t4");
        check("t4_valid_full", 32'(ev_valid), 1);
        check("t4_drop", 32'(drop), 1);
        check("t4_press_cnt", 32'(press_cnt), 5);
        m_nopop  = 1'b0;
        rdy_mode = 1;
        wait_drain("t4_drain");
        check("t4_valid_empty", 32'(ev_valid), 0);
        check_state("t4");

        // Reset discards a pending E0 F0 prefix
        do_reset();
        feed(8'hE0); feed(8'hF0);
        wait_src("t5_prefix");
        do_reset();
        ev_mark = n_ev;
        feed(8'h1C);
        wait_drain("t5");
        check("t5_event_count", 32'(n_ev - ev_mark), 1);
        check_state("t5");

        // Shift keys around a letter, plus a suppressed repeat
        do_reset();
        feed(8'h12); feed(8'h1C); feed(8'hF0); feed(8'h12); feed(8'h1C);
        wait_drain("t6");
        check_state("t6");

        // Randomized traffic with a randomly stalling consumer
        do_reset();
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            k = pool[$urandom_range(0, 17)];
            case ($urandom_range(0, 5))
                0: paced_feed(k);
                1: begin paced_feed(8'hF0); paced_feed(k); end
                2: begin paced_feed(8'hE0); paced_feed(k); end
                3: begin paced_feed(8'hE0); paced_feed(8'hF0); paced_feed(k); end
                4: paced_feed(8'($urandom_range(0, 255)));
                default: begin paced_feed(k); paced_feed(k); end
            endcase
            if (i % 80 == 79) begin
                wait_drain("rand");
                check_state("rand");
            end
        end
        rdy_mode = 1;
        wait_drain("rand_final");
        check_state("rand_final");
        check("rand_final_empty", 32'(ev_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
